// File: rtl/axi_wr_burst_master.sv
// AXI4 write-channel burst master: one AW/W/B transaction per descriptor, address-derived write data.
// Optional response checking (resp_err / resp_err_cnt) is enabled by defining WR_RESP_CHECK_EN.
module axi_wr_burst_master #(
    parameter int DATA_W  = 512,
    parameter int ID_W    = 4,
    parameter int MAX_LEN = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [31:0]           wr_addr,
    input  logic [3:0]            wr_burst_length,
    output logic                  wr_finish,
    output logic                  wlast_hs,
    output logic                  busy,
`ifdef WR_RESP_CHECK_EN
    output logic                  resp_err,
    output logic [15:0]           resp_err_cnt,
`endif
    output logic [ID_W-1:0]       m_axi_awid,
    output logic [31:0]           m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_W-1:0]       m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready
);

    localparam int               BEAT_BYTES = DATA_W / 8;
    localparam int               WORDS      = DATA_W / 32;
    localparam logic [7:0]       MAX_LEN_B  = 8'(MAX_LEN);
    localparam logic [7:0]       MAX_AWLEN  = 8'(MAX_LEN - 1);
    localparam logic [ID_W-1:0]  ID_ONE     = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     awid_q, awid_d;
    logic [31:0]         awaddr_q, awaddr_d;
    logic [7:0]          awlen_q, awlen_d;
    logic [7:0]          beat_q, beat_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                wlast_q, wlast_d;
    logic                bready_q, bready_d;
    logic                wr_finish_q, wr_finish_d;
    logic                wlast_hs_q, wlast_hs_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic [7:0]          req_len;
    logic                aw_hs;
    logic                w_hs;
    logic                b_hs;

    assign req_len = {4'd0, wr_burst_length};
    assign aw_hs   = awvalid_q & m_axi_awready;
    assign w_hs    = wvalid_q & m_axi_wready;
    assign b_hs    = bready_q & m_axi_bvalid;

    // Word i of beat b carries the byte address it would occupy: addr + b*BEAT_BYTES + i*4 (mod 2^32).
    function automatic logic [DATA_W-1:0] beat_pattern(input logic [31:0] addr, input logic [7:0] beat);
        logic [DATA_W-1:0] p;
        logic [31:0]       base;
        base = addr + 32'(beat) * 32'(BEAT_BYTES);
        p    = '0;
        for (int i = 0; i < WORDS; i++) begin
            p[i*32 +: 32] = base + 32'(i * 4);
        end
        return p;
    endfunction

`ifdef WR_RESP_CHECK_EN
    logic        resp_err_q, resp_err_d;
    logic [15:0] resp_err_cnt_q, resp_err_cnt_d;

    always_comb begin
        resp_err_d     = resp_err_q;
        resp_err_cnt_d = resp_err_cnt_q;
        if (state_q == S_B && b_hs && (m_axi_bresp != 2'b00 || m_axi_bid != awid_q)) begin
            resp_err_d = 1'b1;
            if (resp_err_cnt_q != 16'hFFFF) begin
                resp_err_cnt_d = resp_err_cnt_q + 16'd1;
            end
        end
    end

    assign resp_err     = resp_err_q;
    assign resp_err_cnt = resp_err_cnt_q;
`else
    logic unused_bresp;
    assign unused_bresp = ^{m_axi_bid, m_axi_bresp};
`endif

    always_comb begin
        state_d    = state_q;
        awid_d     = awid_q;
        awaddr_d   = awaddr_q;
        awlen_d    = awlen_q;
        beat_d     = beat_q;
        wlast_hs_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (wr_en && req_len != 8'd0) begin
                    awaddr_d = wr_addr;
                    awlen_d  = (req_len > MAX_LEN_B) ? MAX_AWLEN : (req_len - 8'd1);
                    beat_d   = 8'd0;
                    state_d  = S_AW;
                end
            end
            S_AW: begin
                if (aw_hs) begin
                    state_d = S_W;
                end
            end
            S_W: begin
                if (w_hs) begin
                    if (wlast_q) begin
                        wlast_hs_d = 1'b1;
                        state_d    = S_B;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            S_B: begin
                if (b_hs) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                awid_d  = awid_q + ID_ONE;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Channel outputs are registered copies of what the next state implies.
        awvalid_d   = (state_d == S_AW);
        wvalid_d    = (state_d == S_W);
        wlast_d     = (state_d == S_W) && (beat_d == awlen_d);
        bready_d    = (state_d == S_B);
        wr_finish_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
        wdata_d     = (state_d == S_W) ? beat_pattern(awaddr_d, beat_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            awid_q      <= '0;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            beat_q      <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            wlast_q     <= 1'b0;
            bready_q    <= 1'b0;
            wr_finish_q <= 1'b0;
            wlast_hs_q  <= 1'b0;
            busy_q      <= 1'b0;
            wdata_q     <= '0;
`ifdef WR_RESP_CHECK_EN
            resp_err_q     <= 1'b0;
            resp_err_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            awid_q      <= awid_d;
            awaddr_q    <= awaddr_d;
            awlen_q     <= awlen_d;
            beat_q      <= beat_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            wlast_q     <= wlast_d;
            bready_q    <= bready_d;
            wr_finish_q <= wr_finish_d;
            wlast_hs_q  <= wlast_hs_d;
            busy_q      <= busy_d;
            wdata_q     <= wdata_d;
`ifdef WR_RESP_CHECK_EN
            resp_err_q     <= resp_err_d;
            resp_err_cnt_q <= resp_err_cnt_d;
`endif
        end
    end

    assign wr_finish     = wr_finish_q;
    assign wlast_hs      = wlast_hs_q;
    assign busy          = busy_q;
    assign m_axi_awid    = awid_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = 3'd6;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = wlast_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;

    // Only one channel is ever active, and a stalled AW request must not change.
    a_single_channel: assert property (@(posedge clk) disable iff (reset)
        !(m_axi_awvalid && m_axi_wvalid));
    a_aw_stable: assert property (@(posedge clk) disable iff (reset)
        (m_axi_awvalid && !m_axi_awready) |=> (m_axi_awvalid && $stable(m_axi_awaddr) && $stable(m_axi_awlen)));
    a_finish_pulse: assert property (@(posedge clk) disable iff (reset)
        wr_finish |=> !wr_finish);

endmodule

// File: tb/tb_axi_wr_burst_master.sv
// Table-driven bench for axi_wr_burst_master with a simple AXI slave model and beat-level monitor.
// Define WR_RESP_CHECK_EN to also exercise the response-error ports.
module tb_axi_wr_burst_master;

    localparam int DATA_W = 512;
    localparam int ID_W   = 4;
    localparam int STRB_W = DATA_W / 8;

    logic                clk = 1'b0;
    logic                reset;
    logic                wr_en;
    logic [31:0]         wr_addr;
    logic [3:0]          wr_burst_length;
    logic                wr_finish;
    logic                wlast_hs;
    logic                busy;
`ifdef WR_RESP_CHECK_EN
    logic                resp_err;
    logic [15:0]         resp_err_cnt;
`endif
    logic [ID_W-1:0]     m_axi_awid;
    logic [31:0]         m_axi_awaddr;
    logic [7:0]          m_axi_awlen;
    logic [2:0]          m_axi_awsize;
    logic [1:0]          m_axi_awburst;
    logic                m_axi_awvalid;
    logic                m_axi_awready;
    logic [DATA_W-1:0]   m_axi_wdata;
    logic [STRB_W-1:0]   m_axi_wstrb;
    logic                m_axi_wlast;
    logic                m_axi_wvalid;
    logic                m_axi_wready;
    logic [ID_W-1:0]     m_axi_bid;
    logic [1:0]          m_axi_bresp;
    logic                m_axi_bvalid;
    logic                m_axi_bready;

    always #5 clk = ~clk;

    axi_wr_burst_master #(.DATA_W(DATA_W), .ID_W(ID_W), .MAX_LEN(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_burst_length (wr_burst_length),
        .wr_finish       (wr_finish),
        .wlast_hs        (wlast_hs),
        .busy            (busy),
`ifdef WR_RESP_CHECK_EN
        .resp_err        (resp_err),
        .resp_err_cnt    (resp_err_cnt),
`endif
        .m_axi_awid      (m_axi_awid),
        .m_axi_awaddr    (m_axi_awaddr),
        .m_axi_awlen     (m_axi_awlen),
        .m_axi_awsize    (m_axi_awsize),
        .m_axi_awburst   (m_axi_awburst),
        .m_axi_awvalid   (m_axi_awvalid),
        .m_axi_awready   (m_axi_awready),
        .m_axi_wdata     (m_axi_wdata),
        .m_axi_wstrb     (m_axi_wstrb),
        .m_axi_wlast     (m_axi_wlast),
        .m_axi_wvalid    (m_axi_wvalid),
        .m_axi_wready    (m_axi_wready),
        .m_axi_bid       (m_axi_bid),
        .m_axi_bresp     (m_axi_bresp),
        .m_axi_bvalid    (m_axi_bvalid),
        .m_axi_bready    (m_axi_bready)
    );

    typedef struct {
        logic [31:0]     addr;
        logic [3:0]      len;
        int              aw_hold;
        bit              w_toggle;
        logic [7:0]      exp_awlen;
        int              exp_beats;
        logic [31:0]     exp_first;
        logic [31:0]     exp_last;
        logic [ID_W-1:0] exp_awid;
    } vec_t;

    vec_t vecs[6];

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;

    int              aw_hold;
    int              aw_wait;
    bit              w_toggle;
    bit              w_phase;
    logic [1:0]      cur_bresp;
    logic [ID_W-1:0] slave_bid;
    logic [31:0]     mdl_addr;
    int              mdl_beats;

    int              mon_awvalid_cyc, mon_busy_cyc, mon_aw_hs, mon_w_hs, mon_beat;
    int              mon_wlast_cnt, mon_wlast_beat, mon_wlast_early, mon_wlast_hs, mon_finish;
    int              mon_data_err, mon_aw_unstable, mon_w_unstable, mon_early_w;
    int              mon_aw_cycle[2];
    bit              mon_aw_open;
    logic [31:0]     mon_awaddr;
    logic [7:0]      mon_awlen;
    logic [ID_W-1:0] mon_awid, mon_awid_first;
    logic [2:0]      mon_awsize;
    logic [1:0]      mon_awburst;
    logic [31:0]     mon_first_word, mon_last_word;
    bit              prev_aw_stall, prev_w_stall, prev_wlast;
    logic [31:0]     prev_awaddr;
    logic [7:0]      prev_awlen;
    logic [DATA_W-1:0] prev_wdata;

    function automatic logic [DATA_W-1:0] model_beat(input logic [31:0] base, input int b);
        logic [DATA_W-1:0] r;
        logic [31:0]       start;
        start = base + 32'(b) * 32'd64;
        for (int i = 0; i < DATA_W / 32; i++) begin
            r[i*32 +: 32] = start + 32'(i) * 32'd4;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clear_mon();
        aw_wait = 0; w_phase = 1'b1;
        mon_awvalid_cyc = 0; mon_busy_cyc = 0; mon_aw_hs = 0; mon_w_hs = 0; mon_beat = 0;
        mon_wlast_cnt = 0; mon_wlast_beat = -1; mon_wlast_early = 0; mon_wlast_hs = 0; mon_finish = 0;
        mon_data_err = 0; mon_aw_unstable = 0; mon_w_unstable = 0; mon_early_w = 0;
        mon_aw_cycle[0] = 0; mon_aw_cycle[1] = 0; mon_aw_open = 1'b0;
        mon_awaddr = '0; mon_awlen = '0; mon_awid = '0; mon_awid_first = '0;
        mon_awsize = '0; mon_awburst = '0; mon_first_word = '0; mon_last_word = '0;
        prev_aw_stall = 1'b0; prev_w_stall = 1'b0; prev_wlast = 1'b0;
        prev_awaddr = '0; prev_awlen = '0; prev_wdata = '0;
    endtask

    // Observes the values the coming rising edge will act on; called at the falling edge.
    task automatic monitor();
        if (m_axi_awvalid) mon_awvalid_cyc++;
        if (busy) mon_busy_cyc++;
        if (prev_aw_stall && (!m_axi_awvalid || m_axi_awaddr !== prev_awaddr || m_axi_awlen !== prev_awlen))
            mon_aw_unstable++;
        prev_aw_stall = m_axi_awvalid && !m_axi_awready;
        prev_awaddr   = m_axi_awaddr;
        prev_awlen    = m_axi_awlen;
        if (m_axi_wvalid && !mon_aw_open) mon_early_w++;
        if (m_axi_awvalid && m_axi_awready) begin
            if (mon_aw_hs < 2) mon_aw_cycle[mon_aw_hs] = cycle;
            if (mon_aw_hs == 0) mon_awid_first = m_axi_awid;
            mon_aw_hs++;
            mon_awaddr  = m_axi_awaddr;
            mon_awlen   = m_axi_awlen;
            mon_awid    = m_axi_awid;
            mon_awsize  = m_axi_awsize;
            mon_awburst = m_axi_awburst;
            slave_bid   = m_axi_awid;
            mon_aw_open = 1'b1;
        end
        if (prev_w_stall && (!m_axi_wvalid || m_axi_wdata !== prev_wdata || m_axi_wlast !== prev_wlast))
            mon_w_unstable++;
        prev_w_stall = m_axi_wvalid && !m_axi_wready;
        prev_wdata   = m_axi_wdata;
        prev_wlast   = m_axi_wlast;
        if (m_axi_wvalid && m_axi_wlast && mon_beat != mdl_beats - 1) mon_wlast_early++;
        if (m_axi_wvalid && m_axi_wready) begin
            if (m_axi_wdata !== model_beat(mdl_addr, mon_beat) || m_axi_wstrb !== '1) mon_data_err++;
            if (mon_beat == 0) mon_first_word = m_axi_wdata[31:0];
            mon_last_word = m_axi_wdata[DATA_W-1 -: 32];
            mon_w_hs++;
            if (m_axi_wlast) begin
                mon_wlast_cnt++;
                mon_wlast_beat = mon_beat;
                mon_beat       = 0;
                mon_aw_open    = 1'b0;
            end else begin
                mon_beat++;
            end
        end
        if (wlast_hs) mon_wlast_hs++;
        if (wr_finish) mon_finish++;
    endtask

    // One clock: slave model reacts just after the rising edge, monitor samples at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
        m_axi_awready = (aw_wait >= aw_hold);
        if (m_axi_awvalid) aw_wait++;
        m_axi_wready = w_toggle ? w_phase : 1'b1;
        if (w_toggle && m_axi_wvalid) w_phase = !w_phase;
        m_axi_bvalid = m_axi_bready;
        m_axi_bresp  = cur_bresp;
        m_axi_bid    = slave_bid;
        @(negedge clk);
        monitor();
    endtask

    task automatic applyStimulus(input vec_t v, output bit done);
        clear_mon();
        aw_hold         = v.aw_hold;
        w_toggle        = v.w_toggle;
        mdl_addr        = v.addr;
        mdl_beats       = v.exp_beats;
        wr_addr         = v.addr;
        wr_burst_length = v.len;
        wr_en           = 1'b1;
        tick();
        wr_en = 1'b0;
        done  = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            tick();
            if (mon_finish != 0) done = 1'b1;
        end
        repeat (3) tick();
    endtask

    task automatic checkVector(input string tag, input vec_t v, input bit done);
        checkOutput({tag, "_done"},        32'(done), 32'd1);
        checkOutput({tag, "_aw_hs"},       32'(mon_aw_hs), 32'd1);
        checkOutput({tag, "_awaddr"},      mon_awaddr, v.addr);
        checkOutput({tag, "_awlen"},       32'(mon_awlen), 32'(v.exp_awlen));
        checkOutput({tag, "_awid"},        32'(mon_awid), 32'(v.exp_awid));
        checkOutput({tag, "_awsize"},      32'(mon_awsize), 32'd6);
        checkOutput({tag, "_awburst"},     32'(mon_awburst), 32'd1);
        checkOutput({tag, "_awvalid_cyc"}, 32'(mon_awvalid_cyc), 32'(v.aw_hold + 1));
        checkOutput({tag, "_aw_stable"},   32'(mon_aw_unstable), 32'd0);
        checkOutput({tag, "_early_w"},     32'(mon_early_w), 32'd0);
        checkOutput({tag, "_w_beats"},     32'(mon_w_hs), 32'(v.exp_beats));
        checkOutput({tag, "_wlast_cnt"},   32'(mon_wlast_cnt), 32'd1);
        checkOutput({tag, "_wlast_beat"},  32'(mon_wlast_beat), 32'(v.exp_beats - 1));
        checkOutput({tag, "_wlast_early"}, 32'(mon_wlast_early), 32'd0);
        checkOutput({tag, "_w_stable"},    32'(mon_w_unstable), 32'd0);
        checkOutput({tag, "_data_err"},    32'(mon_data_err), 32'd0);
        checkOutput({tag, "_first_word"},  mon_first_word, v.exp_first);
        checkOutput({tag, "_last_word"},   mon_last_word, v.exp_last);
        checkOutput({tag, "_wlast_hs"},    32'(mon_wlast_hs), 32'd1);
        checkOutput({tag, "_finish"},      32'(mon_finish), 32'd1);
    endtask

    initial begin
        bit   done;
        vec_t post;

        // addr, len, aw_hold, w_toggle, exp_awlen, exp_beats, exp_first, exp_last, exp_awid
        vecs[0] = '{32'h0000_1000, 4'd4,  0,  1'b0, 8'd3, 4, 32'h0000_1000, 32'h0000_10FC, 4'd0};
        vecs[1] = '{32'h0000_2000, 4'd1,  10, 1'b0, 8'd0, 1, 32'h0000_2000, 32'h0000_203C, 4'd1};
        vecs[2] = '{32'h0004_0000, 4'd8,  0,  1'b1, 8'd7, 8, 32'h0004_0000, 32'h0004_01FC, 4'd2};
        vecs[3] = '{32'h0000_3000, 4'd12, 0,  1'b0, 8'd7, 8, 32'h0000_3000, 32'h0000_31FC, 4'd3};
        vecs[4] = '{32'hFFFF_FFC0, 4'd2,  0,  1'b0, 8'd1, 2, 32'hFFFF_FFC0, 32'h0000_003C, 4'd4};
        vecs[5] = '{32'h0000_8000, 4'd3,  2,  1'b1, 8'd2, 3, 32'h0000_8000, 32'h0000_80BC, 4'd5};

        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_burst_length = '0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
        m_axi_bresp = 2'b00; m_axi_bid = '0;
        aw_hold = 0; w_toggle = 1'b0; cur_bresp = 2'b00; slave_bid = '0;
        mdl_addr = '0; mdl_beats = 1;
        clear_mon();

        repeat (3) tick();
        checkOutput("rst_ctrl", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready,
                                     busy, wr_finish, wlast_hs}), 32'd0);
        checkOutput("rst_awid", 32'(m_axi_awid), 32'd0);
        checkOutput("rst_awaddr", m_axi_awaddr, 32'd0);
        checkOutput("rst_awlen", 32'(m_axi_awlen), 32'd0);
`ifdef WR_RESP_CHECK_EN
        checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
        checkOutput("rst_resp_err_cnt", 32'(resp_err_cnt), 32'd0);
`endif
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], done);
            checkVector($sformatf("v%0d", i), vecs[i], done);
        end

        // Zero length with wr_en high must never start a burst.
        clear_mon();
        wr_burst_length = 4'd0; wr_addr = 32'h0000_4000; wr_en = 1'b1;
        repeat (10) tick();
        wr_en = 1'b0;
        checkOutput("len0_awvalid", 32'(mon_awvalid_cyc), 32'd0);
        checkOutput("len0_busy", 32'(mon_busy_cyc), 32'd0);

        // wr_en held high: two back-to-back bursts at the minimum period of len+4 cycles.
        clear_mon();
        aw_hold = 0; w_toggle = 1'b0; mdl_addr = 32'h0000_5000; mdl_beats = 2;
        wr_addr = 32'h0000_5000; wr_burst_length = 4'd2; wr_en = 1'b1;
        for (int c = 0; c < 60 && mon_aw_hs < 2; c++) tick();
        wr_en = 1'b0;
        for (int c = 0; c < 60 && mon_finish < 2; c++) tick();
        repeat (3) tick();
        checkOutput("b2b_aw_hs", 32'(mon_aw_hs), 32'd2);
        checkOutput("b2b_period", 32'(mon_aw_cycle[1] - mon_aw_cycle[0]), 32'd6);
        checkOutput("b2b_awid0", 32'(mon_awid_first), 32'd6);
        checkOutput("b2b_awid1", 32'(mon_awid), 32'd7);
        checkOutput("b2b_w_beats", 32'(mon_w_hs), 32'd4);
        checkOutput("b2b_data_err", 32'(mon_data_err), 32'd0);
        checkOutput("b2b_finish", 32'(mon_finish), 32'd2);
        checkOutput("b2b_wlast_hs", 32'(mon_wlast_hs), 32'd2);

        // Reset after two of five beats: burst abandoned, no completion, awid restarts.
        clear_mon();
        mdl_addr = 32'h0000_6000; mdl_beats = 5;
        wr_addr = 32'h0000_6000; wr_burst_length = 4'd5; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        for (int c = 0; c < 50 && mon_w_hs < 2; c++) tick();
        tick();
        reset = 1'b1;
        tick();
        checkOutput("midrst_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready}), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (6) tick();
        checkOutput("midrst_no_finish", 32'(mon_finish), 32'd0);
        checkOutput("midrst_no_wlast_hs", 32'(mon_wlast_hs), 32'd0);

        post = '{32'h0000_7000, 4'd2, 0, 1'b0, 8'd1, 2, 32'h0000_7000, 32'h0000_707C, 4'd0};
        applyStimulus(post, done);
        checkVector("postrst", post, done);

`ifdef WR_RESP_CHECK_EN
        cur_bresp = 2'b10;
        post = '{32'h0000_9000, 4'd1, 0, 1'b0, 8'd0, 1, 32'h0000_9000, 32'h0000_903C, 4'd1};
        applyStimulus(post, done);
        checkOutput("slverr_done", 32'(done), 32'd1);
        checkOutput("slverr_resp_err", 32'(resp_err), 32'd1);
        checkOutput("slverr_cnt", 32'(resp_err_cnt), 32'd1);
        cur_bresp = 2'b00;
        post = '{32'h0000_A000, 4'd1, 0, 1'b0, 8'd0, 1, 32'h0000_A000, 32'h0000_A03C, 4'd2};
        applyStimulus(post, done);
        checkOutput("okay_done", 32'(done), 32'd1);
        checkOutput("okay_resp_err_sticky", 32'(resp_err), 32'd1);
        checkOutput("okay_cnt", 32'(resp_err_cnt), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
